// File: rtl/conv_mac_array.sv
// conv_mac_array: 1xK multi-channel multiply-accumulate array.
// Takes one signed pixel per handshake and applies it to every channel,
// each channel using its own K-tap weight set. After each K-th pixel it
// emits one biased, optionally rectified and saturated result per channel.
// Completed windows are counted up to N_OUT, which marks the frame done.
module conv_mac_array #(
    parameter int KERNEL_SIZE = 3,
    parameter int N_CH        = 16,
    parameter int DATA_W      = 8,
    parameter int WEIGHT_W    = 8,
    parameter int BIAS_W      = 8,
    parameter int SHIFT       = 9,
    parameter int ACC_W       = 30,
    parameter int N_OUT       = 1260,
    parameter int CNT_W       = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      w_load,
    input  logic [N_CH*WEIGHT_W-1:0]  w_in,
    input  logic                      b_load,
    input  logic [N_CH*BIAS_W-1:0]    b_in,
    input  logic                      relu_en,
    input  logic                      clear,
    output logic [N_CH*ACC_W-1:0]     out_data,
    output logic                      out_valid,
    output logic [CNT_W-1:0]          out_count,
    output logic                      done
);

    // Tap pointer width, scaled pixel / product widths and the internal
    // accumulator width (two guard bits above the result width so that
    // a K-tap sum plus bias can be saturated rather than wrapped).
    // The product must be narrower than INT_W for the sign extension below.
    localparam int PTR_W  = $clog2(KERNEL_SIZE);
    localparam int PIX_W  = DATA_W + SHIFT;
    localparam int PROD_W = PIX_W + WEIGHT_W;
    localparam int INT_W  = ACC_W + 2;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_reg;
    logic [PTR_W-1:0]           wptr_reg;
    logic [PTR_W-1:0]           s_reg;
    logic signed [WEIGHT_W-1:0] w_bank_reg [KERNEL_SIZE][N_CH];
    logic signed [BIAS_W-1:0]   b_reg      [N_CH];
    logic signed [INT_W-1:0]    acc_reg    [N_CH];
    logic [ACC_W-1:0]           out_res_reg[N_CH];
    logic                       out_valid_reg;
    logic [CNT_W-1:0]           out_count_reg;
    logic                       done_reg;

    logic signed [INT_W-1:0]    acc_next   [N_CH];
    logic [ACC_W-1:0]           res_sat    [N_CH];

    logic                       xfer;
    logic                       last_tap;
    logic [CNT_W-1:0]           count_next;
    logic signed [PIX_W-1:0]    pix_scaled;

    // Ready only while running and no reload/restart is requested this cycle.
    assign in_ready   = (state_reg == ST_RUN) && !w_load && !clear;
    assign xfer       = in_valid && in_ready;
    assign last_tap   = (s_reg == PTR_W'(KERNEL_SIZE - 1));
    assign count_next = out_count_reg + CNT_W'(1);
    assign pix_scaled = $signed({data_in, {SHIFT{1'b0}}});

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : gen_ch
            logic signed [WEIGHT_W-1:0] w_sel;
            logic signed [PROD_W-1:0]   prod;
            logic signed [INT_W-1:0]    prod_ext;
            logic signed [INT_W-1:0]    acc_base;
            logic signed [INT_W-1:0]    bias_ext;
            logic signed [INT_W-1:0]    res_sum;
            logic signed [INT_W-1:0]    res_relu;
            logic                       res_ovf;

            // Per-channel MAC datapath: product, accumulation, bias, ReLU, saturation.
            assign w_sel    = w_bank_reg[s_reg][gi];
            assign prod     = $signed({{WEIGHT_W{pix_scaled[PIX_W-1]}}, pix_scaled})
                            * $signed({{PIX_W{w_sel[WEIGHT_W-1]}}, w_sel});
            assign prod_ext = $signed({{(INT_W-PROD_W){prod[PROD_W-1]}}, prod});
            // Tap 0 starts a fresh window, so the previous sum is dropped.
            assign acc_base = (s_reg == '0) ? '0 : acc_reg[gi];
            assign acc_next[gi] = acc_base + prod_ext;
            assign bias_ext = $signed({{(INT_W-BIAS_W-SHIFT){b_reg[gi][BIAS_W-1]}},
                                       b_reg[gi], {SHIFT{1'b0}}});
            assign res_sum  = acc_next[gi] + bias_ext;
            assign res_relu = (relu_en && res_sum[INT_W-1]) ? '0 : res_sum;
            // Overflow when the guard bits and the result sign bit disagree.
            assign res_ovf  = !(&res_relu[INT_W-1:ACC_W-1]) && (|res_relu[INT_W-1:ACC_W-1]);
            assign res_sat[gi] = !res_ovf          ? res_relu[ACC_W-1:0] :
                                 res_relu[INT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                                     {1'b0, {(ACC_W-1){1'b1}}};

            // Pack the registered per-channel result onto the output bus.
            assign out_data[gi*ACC_W +: ACC_W] = out_res_reg[gi];
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign done      = done_reg;

    // Control FSM, weight/bias storage, accumulators and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            wptr_reg      <= '0;
            s_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            done_reg      <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                b_reg[c]       <= '0;
                acc_reg[c]     <= '0;
                out_res_reg[c] <= '0;
                for (int t = 0; t < KERNEL_SIZE; t++) begin
                    w_bank_reg[t][c] <= '0;
                end
            end
        end else begin
            out_valid_reg <= 1'b0;

            // Bias updates are independent of the FSM; a window finishing
            // this cycle still sees the old value.
            if (b_load) begin
                for (int c = 0; c < N_CH; c++) begin
                    b_reg[c] <= $signed(b_in[c*BIAS_W +: BIAS_W]);
                end
            end

            if (w_load) begin
                if (state_reg == ST_LOAD) begin
                    for (int c = 0; c < N_CH; c++) begin
                        w_bank_reg[wptr_reg][c] <= $signed(w_in[c*WEIGHT_W +: WEIGHT_W]);
                    end
                    if (wptr_reg == PTR_W'(KERNEL_SIZE - 1)) begin
                        wptr_reg  <= '0;
                        state_reg <= ST_RUN;
                    end else begin
                        wptr_reg <= wptr_reg + PTR_W'(1);
                    end
                end else begin
                    // Reload from RUN/DONE: drop the partial window and
                    // restart the weight sequence at tap 0.
                    for (int c = 0; c < N_CH; c++) begin
                        w_bank_reg[0][c] <= $signed(w_in[c*WEIGHT_W +: WEIGHT_W]);
                    end
                    wptr_reg  <= PTR_W'(1);
                    s_reg     <= '0;
                    state_reg <= ST_LOAD;
                end
            end else if (clear && (state_reg != ST_LOAD)) begin
                s_reg         <= '0;
                out_count_reg <= '0;
                done_reg      <= 1'b0;
                state_reg     <= ST_RUN;
            end else if (xfer) begin
                for (int c = 0; c < N_CH; c++) begin
                    acc_reg[c] <= acc_next[c];
                end
                if (last_tap) begin
                    s_reg         <= '0;
                    out_valid_reg <= 1'b1;
                    out_count_reg <= count_next;
                    for (int c = 0; c < N_CH; c++) begin
                        out_res_reg[c] <= res_sat[c];
                    end
                    if (count_next == CNT_W'(N_OUT)) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end else begin
                    s_reg <= s_reg + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/conv_mac_array.md
# conv_mac_array

Parametrised 1×K multi-channel multiply-accumulate array for the conv2 stage. It accepts one signed pixel per handshake and applies it to N_CH output channels in parallel, each with its own K-tap weight set. After every K accepted pixels it emits one pre-scaled, biased, optionally ReLU'd and saturated result per channel. It counts completed windows up to N_OUT and then signals frame completion. This is the generalised successor of the fixed 16-channel, 3-tap conv2 MAC bank: it adds bias, ReLU, saturation, backpressure and a clean restart.

## Interface
- KERNEL_SIZE, 3, taps per window (2..7)
- N_CH, 16, parallel output channels
- DATA_W, 8, signed pixel width
- WEIGHT_W, 8, signed weight width
- BIAS_W, 8, signed bias width
- SHIFT, 9, pixel and bias pre-scale (left shift, i.e. ×512)
- ACC_W, 30, signed accumulator/result width per channel
- N_OUT, 1260, windows per frame (30×42)
- CNT_W, 11, width of out_count
- clk, in, 1, clock; all state changes on rising edge
- rst, in, 1, asynchronous active-high reset
- data_in, in, DATA_W, signed pixel
- in_valid, in, 1, pixel valid
- in_ready, out, 1, block can accept a pixel; transfer = in_valid & in_ready
- w_load, in, 1, load one tap's weights for all channels
- w_in, in, N_CH*WEIGHT_W, channel c at bits [WEIGHT_W*(c+1)-1 : WEIGHT_W*c]
- b_load, in, 1, load biases for all channels
- b_in, in, N_CH*BIAS_W, per-channel biases, same packing
- relu_en, in, 1, clamp negative results to 0
- clear, in, 1, synchronous frame restart (weights and biases kept)
- out_data, out, N_CH*ACC_W, per-channel results, same packing
- out_valid, out, 1, one-cycle strobe, out_data valid
- out_count, out, CNT_W, windows emitted this frame
- done, out, 1, high once out_count == N_OUT

## Operation
- States: LOAD, RUN, DONE. Reset enters LOAD.
- Reset clears tap pointer, sample counter, accumulators, weights, biases, out_data, out_valid, out_count and done to 0.
- **LOAD**
  - in_ready = 0.
  - Each w_load cycle writes w_in into weight bank[wptr], then wptr increments.
  - When wptr reaches KERNEL_SIZE-1 and is written, wptr wraps to 0 and the state goes to RUN.
- **RUN**
  - in_ready = 1.
  - Each transfer uses tap index s, the sample counter (0..K-1). p = sign_ext(data_in) << SHIFT.
  - For each channel c: acc[c] = (s==0 ? 0 : acc[c]) + p*w[s][c]. The product is DATA_W+SHIFT+WEIGHT_W bits, sign-extended to ACC_W+2 internally.
  - On s == K-1: r = acc_next + (sign_ext(b[c]) << SHIFT). If relu_en and r<0, r=0. Saturate r to the signed ACC_W range, register it into out_data, pulse out_valid, increment out_count, and reset s to 0.
  - If out_count becomes N_OUT, go to DONE.
- **DONE**
  - in_ready = 0 and done = 1.
  - out_data holds the last result.
- b_load is accepted in any state. The new biases apply to windows finishing in later cycles. If b_load coincides with a window's final sample, that window uses the old bias.
- w_load in RUN or DONE:
  - The partial window is discarded (s=0).
  - The write goes to tap 0 and wptr becomes 1.
  - The state goes to LOAD; out_count is unchanged.
  - w_load takes priority over a same-cycle transfer, which is refused because in_ready is 0 that cycle.
- clear (any state except LOAD):
  - Sets s=0, out_count=0 and done=0, and goes to RUN.
  - Has priority over a same-cycle transfer; in_ready is 0 during clear.
  - clear in LOAD is ignored.
- Priority order: rst > w_load > clear > transfer.
- in_ready is combinational from state, w_load and clear only; it never depends on in_valid.

## Timing
- out_valid is asserted the cycle after the rising edge that accepted the K-th sample. Latency is 1 clock and throughput is 1 window per K transfers.
- Back-to-back transfers are fully supported, with no bubble between windows.
- out_count and done update on the same edge that sets out_valid.
- in_ready drops in the cycle done rises.
- Gaps in in_valid stall the window without losing partial sums.
- Asynchronous rst mid-window clears all state immediately. Weights must be reloaded after reset.

## Test plan
- **Load, single window.** Load w[t][c]=1 for all t,c, b=0, relu off, then send pixels 1,2,3 → one out_valid; every channel = 6·512 = 3072; out_count=1.
- **Bias, ReLU, saturation.**
  - Weights −1, b=2, pixels 1,1,1: relu off gives (−3+2)·512 = −512; relu on gives 0.
  - Weights 127, pixels 127,127,127, b=127: r = 127·127·3·512 + 127·512 = 24,839,168. This is below 2^29 with ACC_W=30, so no saturation. Set ACC_W=24 for this case → saturates at 8,388,607.
- **Frame end.** Stream 3·1260 pixels back-to-back → 1260 out_valid strobes at every third cycle; done=1 and in_ready=0 after the last one; extra in_valid is ignored.
- **Backpressure/gaps.** Random in_valid gaps across the window boundary produce results identical to gap-free streaming.
- **Mid-window reload.** After 2 samples, assert w_load with new weights → no out_valid; the next full window uses only the new weights. Also check a bias update coinciding with a final sample: that window uses the old bias, the next uses the new one.
- **clear/rst.** clear in DONE gives out_count=0 and a RUN window valid again. rst asserted mid-window drives all outputs to 0 asynchronously and in_ready to 0 until weights are reloaded.
